// File: rtl/mips_cpu_hilo_pkg.sv
// Shared types for the HI/LO sequencer: request opcodes, FSM states, default timeout.
package mips_cpu_hilo_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'd0,
    DIVU = 2'd1,
    MTHI = 2'd2,
    MTLO = 2'd3
  } hilo_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } hilo_state_t;

  localparam int DEFAULT_TIMEOUT_CYCLES = 40;

endpackage

// File: rtl/mips_cpu_hilo_ctrl.sv
// HI/LO register pair plus start/wait/abort sequencing for the external iterative divider.
// Define MIPS_CPU_HILO_FWD_EN to forward a completing divide result to hi/lo/MF reads in the done cycle.
module mips_cpu_hilo_ctrl
  import mips_cpu_hilo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int CNT_W          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mf_req,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_start,
  output logic        div_reset,
  output logic        div_sign,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_done,
  input  logic        div_dbz,
  output logic        timeout_err
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  hilo_state_t      state;
  hilo_op_t         op_e;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q;
  logic             abort_q;

  assign op_e      = hilo_op_t'(op);
  assign busy      = (state != IDLE);
  assign div_reset = reset | abort_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      div_start    <= 1'b0;
      div_sign     <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      abort_q      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      div_start <= 1'b0;
      abort_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            case (op_e)
              DIV, DIVU: begin
                div_dividend <= rs_data;
                div_divisor  <= rt_data;
                div_sign     <= (op_e == DIV);
                // Zero divisor completes here: the divider is never launched.
                if (rt_data != '0) begin
                  state     <= ISSUE;
                  div_start <= 1'b1;
                end
              end
              MTHI: hi_q <= rs_data;
              MTLO: lo_q <= rs_data;
              default: ;
            endcase
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (div_done) begin
            if (!div_dbz) begin
              lo_q <= div_quotient;
              hi_q <= div_remainder;
            end
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            // Divider hung: kick it with a reset pulse next cycle and flag the loss.
            abort_q     <= 1'b1;
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MIPS_CPU_HILO_FWD_EN
  logic fwd_hit;
  assign fwd_hit = (state == WAIT) && div_done && !div_dbz;
  assign hi      = fwd_hit ? div_remainder : hi_q;
  assign lo      = fwd_hit ? div_quotient  : lo_q;
  // A pending MTHI/MTLO must still wait for IDLE; only reads ride the forward path.
  assign stall   = busy & (op_valid | (mf_req & ~fwd_hit));
`else
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign stall   = busy & (mf_req | op_valid);
`endif

endmodule
